// File: rtl/k16_pkg.sv
// k16 shared definitions: opcodes, ALU functions, branch conditions,
// panel button bits and control-state encoding.
package k16_pkg;

    typedef enum logic [2:0] {
        OP_ALU  = 3'd0,
        OP_ADDI = 3'd1,
        OP_JNZ  = 3'd2,
        OP_MOVI = 3'd3,
        OP_JMP  = 3'd4,
        OP_JAL  = 3'd5,
        OP_LD   = 3'd6,
        OP_ST   = 3'd7
    } op_e;

    localparam logic [3:0] FN_ADD = 4'd0;
    localparam logic [3:0] FN_SUB = 4'd1;
    localparam logic [3:0] FN_AND = 4'd2;
    localparam logic [3:0] FN_OR  = 4'd3;
    localparam logic [3:0] FN_XOR = 4'd4;
    localparam logic [3:0] FN_SHL = 4'd5;
    localparam logic [3:0] FN_SHR = 4'd6;
    localparam logic [3:0] FN_ASR = 4'd7;

    localparam logic [2:0] CC_Z   = 3'd0;
    localparam logic [2:0] CC_NZ  = 3'd1;
    localparam logic [2:0] CC_C   = 3'd2;
    localparam logic [2:0] CC_NC  = 3'd3;
    localparam logic [2:0] CC_N   = 3'd4;
    localparam logic [2:0] CC_NN  = 3'd5;
    localparam logic [2:0] CC_NEV = 3'd6;
    localparam logic [2:0] CC_ALW = 3'd7;

    localparam int BTN_START = 0;
    localparam int BTN_STOP  = 1;
    localparam int BTN_STEP  = 2;
    localparam int BTN_CONT  = 3;
    localparam int BTN_EXAM  = 4;
    localparam int BTN_EXNX  = 5;
    localparam int BTN_DEP   = 6;

    typedef enum logic [2:0] {
        S_STOP,
        S_PAN_ADDR,
        S_PAN_RD,
        S_PAN_WR,
        S_FETCH,
        S_FETCH_WAIT,
        S_EXEC,
        S_MEM_WAIT
    } state_e;

    function automatic logic [15:0] sext7(input logic [6:0] v);
        return {{9{v[6]}}, v};
    endfunction

    function automatic logic [15:0] sext10(input logic [9:0] v);
        return {{6{v[9]}}, v};
    endfunction

endpackage

// File: rtl/k16_alu.sv
// k16 combinational ALU: arithmetic, logic and single-bit shifts
// with carry/borrow, zero and negative outputs.
module k16_alu
    import k16_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [3:0]  fn,
    output logic [15:0] result,
    output logic        c,
    output logic        z,
    output logic        n
);

    logic [16:0] wide;

    always_comb begin
        result = '0;
        c      = 1'b0;
        wide   = '0;
        case (fn)
            FN_ADD: begin
                wide   = {1'b0, a} + {1'b0, b};
                result = wide[15:0];
                c      = wide[16];
            end
            FN_SUB: begin
                // bit 16 of the 17-bit difference is the borrow
                wide   = {1'b0, a} - {1'b0, b};
                result = wide[15:0];
                c      = wide[16];
            end
            FN_AND: result = a & b;
            FN_OR:  result = a | b;
            FN_XOR: result = a ^ b;
            FN_SHL: begin
                result = {a[14:0], 1'b0};
                c      = a[15];
            end
            FN_SHR: begin
                result = {1'b0, a[15:1]};
                c      = a[0];
            end
            FN_ASR: begin
                result = {a[15], a[15:1]};
                c      = a[0];
            end
            default: ;
        endcase
    end

    assign z = (result == 16'h0000);
    assign n = result[15];

endmodule

// File: rtl/k16_cpu.sv
// k16 CPU core: register file, fetch/execute control and the
// front-panel start/stop/step/examine/deposit logic.
module k16_cpu
    import k16_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        hold,
    output logic        busy,
    output logic [15:0] address,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        write,
    input  logic [15:0] cpuInput0,
    input  logic [15:0] cpuInput1,
    output logic [15:0] cpuOutput0,
    output logic [15:0] cpuOutput1
);

    state_e      state, state_nx;
    logic [15:0] regs [8];
    logic [15:0] pc, ir, pan_addr, pan_data;
    logic        flag_z, flag_c, flag_n;
    logic [6:0]  btn_q, btn_edge;
    logic        stop_req, step_mode;
    logic        unused_btn;

    assign btn_edge   = cpuInput1[6:0] & ~btn_q;
    assign unused_btn = ^cpuInput1[15:7];

    op_e         op;
    logic [2:0]  rd, ra, rb;
    logic [15:0] imm7, off10, base, ea;
    logic [15:0] alu_b, alu_r;
    logic [3:0]  alu_fn;
    logic        alu_c, alu_z, alu_n;
    logic        cond_ok, running, halt_after;

    assign op     = op_e'(ir[15:13]);
    assign rd     = ir[12:10];
    assign ra     = ir[9:7];
    assign rb     = ir[6:4];
    assign imm7   = sext7(ir[6:0]);
    assign off10  = sext10(ir[9:0]);
    assign base   = (ra == 3'd7) ? pc : regs[ra];
    assign ea     = base + imm7;
    assign alu_b  = (op == OP_ADDI) ? imm7 : regs[rb];
    assign alu_fn = (op == OP_ADDI) ? FN_ADD : ir[3:0];

    k16_alu u_alu (
        .a      (regs[ra]),
        .b      (alu_b),
        .fn     (alu_fn),
        .result (alu_r),
        .c      (alu_c),
        .z      (alu_z),
        .n      (alu_n)
    );

    always_comb begin
        cond_ok = 1'b0;
        case (rd)
            CC_Z:   cond_ok = flag_z;
            CC_NZ:  cond_ok = !flag_z;
            CC_C:   cond_ok = flag_c;
            CC_NC:  cond_ok = !flag_c;
            CC_N:   cond_ok = flag_n;
            CC_NN:  cond_ok = !flag_n;
            CC_NEV: cond_ok = 1'b0;
            CC_ALW: cond_ok = 1'b1;
            default: ;
        endcase
    end

    assign running = state inside {S_FETCH, S_FETCH_WAIT,
                                   S_EXEC, S_MEM_WAIT};
    // a STOP edge in the final cycle still counts for this instruction
    assign halt_after = stop_req | step_mode | btn_edge[BTN_STOP];

    logic [15:0] addr_c, dout_c;
    logic        wr_c;

    always_comb begin
        state_nx = state;
        addr_c   = '0;
        dout_c   = '0;
        wr_c     = 1'b0;
        unique case (state)
            S_STOP: begin
                if (btn_edge[BTN_START] || btn_edge[BTN_CONT]
                    || btn_edge[BTN_STEP])
                    state_nx = S_FETCH;
                else if (btn_edge[BTN_EXAM] || btn_edge[BTN_EXNX])
                    state_nx = S_PAN_ADDR;
                else if (btn_edge[BTN_DEP])
                    state_nx = S_PAN_WR;
            end
            S_PAN_ADDR: begin
                addr_c   = pan_addr;
                state_nx = S_PAN_RD;
            end
            S_PAN_RD: state_nx = S_STOP;
            S_PAN_WR: begin
                addr_c   = pan_addr;
                dout_c   = pan_data;
                wr_c     = 1'b1;
                state_nx = S_STOP;
            end
            S_FETCH: begin
                addr_c   = pc;
                state_nx = S_FETCH_WAIT;
            end
            S_FETCH_WAIT: state_nx = S_EXEC;
            S_EXEC: begin
                if (op == OP_LD) begin
                    addr_c   = ea;
                    state_nx = S_MEM_WAIT;
                end else begin
                    if (op == OP_ST) begin
                        addr_c = ea;
                        dout_c = regs[rd];
                        wr_c   = 1'b1;
                    end
                    state_nx = halt_after ? S_STOP : S_FETCH;
                end
            end
            S_MEM_WAIT: state_nx = halt_after ? S_STOP : S_FETCH;
        endcase
    end

    // reset masks the bus so an aborted store never reaches memory
    assign address    = reset ? 16'h0 : addr_c;
    assign data_out   = reset ? 16'h0 : dout_c;
    assign write      = wr_c & ~reset;
    assign hold       = reset | ~running;
    assign busy       = ~reset & (state != S_STOP);
    assign cpuOutput0 = hold ? pan_addr : pc;
    assign cpuOutput1 = hold ? pan_data : ir;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_STOP;
            pc        <= RESET_PC;
            ir        <= '0;
            pan_addr  <= '0;
            pan_data  <= '0;
            flag_z    <= 1'b0;
            flag_c    <= 1'b0;
            flag_n    <= 1'b0;
            btn_q     <= '0;
            stop_req  <= 1'b0;
            step_mode <= 1'b0;
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else begin
            state <= state_nx;
            btn_q <= cpuInput1[6:0];
            if (running && btn_edge[BTN_STOP]) stop_req <= 1'b1;
            unique case (state)
                S_STOP: begin
                    stop_req <= 1'b0;
                    if (btn_edge[BTN_START]) begin
                        pc        <= cpuInput0;
                        step_mode <= 1'b0;
                    end else if (btn_edge[BTN_CONT]) begin
                        step_mode <= 1'b0;
                    end else if (btn_edge[BTN_STEP]) begin
                        step_mode <= 1'b1;
                    end else if (btn_edge[BTN_EXAM]) begin
                        pan_addr <= cpuInput0;
                    end else if (btn_edge[BTN_EXNX]) begin
                        pan_addr <= pan_addr + 16'd1;
                    end else if (btn_edge[BTN_DEP]) begin
                        pan_data <= cpuInput0;
                    end
                end
                S_PAN_RD: pan_data <= data_in;
                S_FETCH_WAIT: begin
                    ir <= data_in;
                    pc <= pc + 16'd1;
                end
                S_EXEC: begin
                    unique case (op)
                        OP_ALU, OP_ADDI: begin
                            if (op == OP_ADDI || !ir[3]) begin
                                regs[rd] <= alu_r;
                                flag_z   <= alu_z;
                                flag_c   <= alu_c;
                                flag_n   <= alu_n;
                            end
                        end
                        OP_MOVI: begin
                            if (ir[9])
                                regs[rd] <= {ir[7:0], regs[rd][7:0]};
                            else
                                regs[rd] <= {8'h00, ir[7:0]};
                        end
                        OP_JMP: if (cond_ok) pc <= pc + off10;
                        OP_JNZ: begin
                            if (regs[rd] != 16'h0) pc <= pc + off10;
                        end
                        OP_JAL: begin
                            regs[rd] <= pc;
                            pc       <= regs[ra] + imm7;
                        end
                        OP_LD, OP_ST: ;
                    endcase
                end
                S_MEM_WAIT: regs[rd] <= data_in;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_k16_cpu.sv
// Self-checking bench for k16_cpu: panel operations, the demo loop
// program and a table of ALU result/flag vectors.
module tb_k16_cpu;
    import k16_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        hold, busy, write;
    logic [15:0] address, data_in, data_out;
    logic [15:0] cpuInput0, cpuInput1;
    logic [15:0] cpuOutput0, cpuOutput1;

    logic [15:0] mem [0:65535];
    logic        tb_we = 1'b0;
    logic [15:0] tb_addr = '0, tb_wdata = '0;
    int          wr_cnt = 0;
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    k16_cpu dut (
        .clk        (clk),
        .reset      (reset),
        .hold       (hold),
        .busy       (busy),
        .address    (address),
        .data_in    (data_in),
        .data_out   (data_out),
        .write      (write),
        .cpuInput0  (cpuInput0),
        .cpuInput1  (cpuInput1),
        .cpuOutput0 (cpuOutput0),
        .cpuOutput1 (cpuOutput1)
    );

    always @(posedge clk) begin
        if (tb_we) mem[tb_addr] <= tb_wdata;
        else if (write) mem[address] <= data_out;
        data_in <= mem[address];
        if (write) wr_cnt <= wr_cnt + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic load(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        tb_we = 1'b1; tb_addr = a; tb_wdata = d;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    task automatic press(input int b);
        @(negedge clk);
        cpuInput1 = 16'h0001 << b;
        @(negedge clk);
        cpuInput1 = '0;
        @(negedge clk);
    endtask

    task automatic wait_idle(input string nm, input int lim);
        int n = 0;
        while ((hold !== 1'b1 || busy !== 1'b0) && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk(nm, {30'd0, hold, busy}, 32'd2);
    endtask

    task automatic examine(input int b, input logic [15:0] sw);
        cpuInput0 = sw;
        press(b);
        wait_idle("panel_idle", 10);
    endtask

    function automatic logic [15:0] f_movi(input logic [2:0] r,
        input logic hi, input logic [7:0] v);
        return {3'b011, r, hi, 1'b0, v};
    endfunction

    function automatic logic [15:0] f_alu(input logic [2:0] r,
        input logic [2:0] a, input logic [2:0] b, input logic [3:0] f);
        return {3'b000, r, a, b, f};
    endfunction

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  fn;
        logic [15:0] r;
        logic        c;
        logic        z;
        logic        n;
    } alu_vec_t;

    alu_vec_t vecs [10];
    int       w0;
    logic     in_loop;

    task automatic run_from(input logic [15:0] pc0);
        cpuInput0 = pc0;
        press(BTN_START);
        repeat (60) @(negedge clk);
        press(BTN_STOP);
        wait_idle("stop_idle", 20);
    endtask

    initial begin
        vecs[0] = '{16'hFFFF, 16'h0001, FN_ADD, 16'h0000, 1, 1, 0};
        vecs[1] = '{16'h1234, 16'h1234, FN_SUB, 16'h0000, 0, 1, 0};
        vecs[2] = '{16'h0001, 16'h0002, FN_SUB, 16'hFFFF, 1, 0, 1};
        vecs[3] = '{16'hF0F0, 16'h3C3C, FN_AND, 16'h3030, 0, 0, 0};
        vecs[4] = '{16'hF0F0, 16'h0F00, FN_OR,  16'hFFF0, 0, 0, 1};
        vecs[5] = '{16'hAAAA, 16'hAAAA, FN_XOR, 16'h0000, 0, 1, 0};
        vecs[6] = '{16'h8001, 16'h0000, FN_SHL, 16'h0002, 1, 0, 0};
        vecs[7] = '{16'h0003, 16'h0000, FN_SHR, 16'h0001, 1, 0, 0};
        vecs[8] = '{16'h8000, 16'h0000, FN_ASR, 16'hC000, 0, 0, 1};
        vecs[9] = '{16'h7FFF, 16'h0001, FN_ADD, 16'h8000, 0, 0, 1};

        reset = 1'b1;
        cpuInput0 = '0;
        cpuInput1 = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_hold", {31'd0, hold}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_write", {31'd0, write}, 32'd0);
        chk("rst_disp0", {16'd0, cpuOutput0}, 32'h0);
        chk("rst_disp1", {16'd0, cpuOutput1}, 32'h0);

        load(16'h0000, 16'hC383);
        load(16'h0001, 16'h2001);
        load(16'h0002, 16'hE382);
        load(16'h0003, 16'h9FFF);
        load(16'h0004, 16'h000A);
        load(16'h0005, 16'h0000);
        load(16'h0010, 16'hBEEF);

        press(BTN_STEP);
        wait_idle("step1_idle", 20);
        chk("step1_pc", {16'd0, dut.pc}, 32'h1);
        chk("step1_r0", {16'd0, dut.regs[0]}, 32'h000A);
        press(BTN_STEP);
        wait_idle("step2_idle", 20);
        chk("step2_pc", {16'd0, dut.pc}, 32'h2);
        chk("step2_r0", {16'd0, dut.regs[0]}, 32'h000B);

        w0 = wr_cnt;
        press(BTN_CONT);
        repeat (40) @(negedge clk);
        chk("loop_hold", {31'd0, hold}, 32'd0);
        in_loop = (cpuOutput0 == 16'h3) || (cpuOutput0 == 16'h4);
        chk("loop_pc_disp", {31'd0, in_loop}, 32'd1);
        chk("mem5", {16'd0, mem[5]}, 32'h000B);
        chk("st_writes", wr_cnt - w0, 32'd1);

        press(BTN_STOP);
        wait_idle("stop_idle", 12);
        chk("stop_pc", {16'd0, dut.pc}, 32'h3);

        examine(BTN_EXAM, 16'h0000);
        chk("exam_addr", {16'd0, cpuOutput0}, 32'h0000);
        chk("exam_data", {16'd0, cpuOutput1}, 32'hC383);
        examine(BTN_EXNX, 16'h0000);
        chk("exnx_addr", {16'd0, cpuOutput0}, 32'h0001);
        chk("exnx_data", {16'd0, cpuOutput1}, 32'h2001);
        examine(BTN_EXAM, 16'hFFFF);
        examine(BTN_EXNX, 16'h0000);
        chk("wrap_addr", {16'd0, cpuOutput0}, 32'h0000);
        chk("wrap_data", {16'd0, cpuOutput1}, 32'hC383);

        examine(BTN_EXAM, 16'h0010);
        chk("exam10", {16'd0, cpuOutput1}, 32'hBEEF);
        w0 = wr_cnt;
        examine(BTN_DEP, 16'h1234);
        chk("dep_mem", {16'd0, mem[16'h0010]}, 32'h1234);
        chk("dep_pulses", wr_cnt - w0, 32'd1);
        chk("dep_disp0", {16'd0, cpuOutput0}, 32'h0010);
        chk("dep_disp1", {16'd0, cpuOutput1}, 32'h1234);

        for (int i = 0; i < 10; i++) begin
            load(16'h0020, f_movi(3'd1, 1'b0, vecs[i].a[7:0]));
            load(16'h0021, f_movi(3'd1, 1'b1, vecs[i].a[15:8]));
            load(16'h0022, f_movi(3'd2, 1'b0, vecs[i].b[7:0]));
            load(16'h0023, f_movi(3'd2, 1'b1, vecs[i].b[15:8]));
            load(16'h0024, f_alu(3'd3, 3'd1, 3'd2, vecs[i].fn));
            load(16'h0025, {3'b111, 3'd3, 3'd7, 7'd10});
            load(16'h0026, 16'h9FFF);
            load(16'h0030, 16'hDEAD);
            run_from(16'h0020);
            chk($sformatf("alu%0d_r", i), {16'd0, mem[16'h0030]},
                {16'd0, vecs[i].r});
            chk($sformatf("alu%0d_czn", i),
                {29'd0, dut.flag_c, dut.flag_z, dut.flag_n},
                {29'd0, vecs[i].c, vecs[i].z, vecs[i].n});
        end

        load(16'h0040, f_movi(3'd1, 1'b0, 8'h05));
        load(16'h0041, f_movi(3'd2, 1'b0, 8'h05));
        load(16'h0042, f_alu(3'd3, 3'd1, 3'd2, FN_SUB));
        load(16'h0043, {3'b100, CC_Z, 10'd1});
        load(16'h0044, 16'h9FFF);
        load(16'h0045, 16'h9FFF);
        run_from(16'h0040);
        chk("jmpz_pc", {16'd0, dut.pc}, 32'h0045);
        chk("jmpz_zc", {30'd0, dut.flag_z, dut.flag_c}, 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
